// File: rtl/spi_frame_pkg.sv
// Shared types and CRC-16-CCITT constants for the SPI frame receive/transmit path.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    SHIFT,
    CHECK,
    ABORT
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One MSB-first CRC step: no reflection, no final XOR.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_next = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/spi_crc16_ser.sv
// Serial CRC-16-CCITT register, one bit per enable; also used by the transmit path.
module spi_crc16_ser
  import spi_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_next(crc, din);
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampled SPI slave frame receiver with optional CRC-16 trailer and a
// one-deep valid/ready holding register toward the command-memory writer.
//
// state   | meaning
// WAIT_CS | after reset, wait for CS high so a frame already in progress is ignored
// IDLE    | CS high, counters cleared, waiting for CS low
// SHIFT   | collecting bits on sample edges, watching for timeout
// CHECK   | one cycle: judge length/CRC/overflow and deliver
// ABORT   | timed out, discard until CS rises
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int FRAME_BITS  = 408,
  parameter int CRC_EN      = 1,
  parameter int SAMPLE_EDGE = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic                  FRAME_VALID,
  input  logic                  FRAME_READY,
  output logic                  ERR_LEN,
  output logic                  ERR_CRC,
  output logic                  ERR_OVF,
  output logic                  ERR_TO,
  output logic [15:0]           FRAME_CNT,
  output logic                  BUSY
);

  localparam int TOTAL_BITS = FRAME_BITS + 16 * CRC_EN;
  localparam int CW = $clog2(TOTAL_BITS + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_TOTAL = CW'(TOTAL_BITS);
  localparam logic [CW-1:0] CNT_SAT   = CW'(TOTAL_BITS + 1);
  localparam logic [CW-1:0] CNT_PAY   = CW'(FRAME_BITS);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_s, cs_s, mosi_s, sample;
  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic [TOTAL_BITS-1:0]  shreg;
  logic [TW-1:0]          to_cnt;
  logic [15:0]            crc;
  logic                   crc_init, crc_en, crc_bad;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign sample = (SAMPLE_EDGE == 0) ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev);

  // CRC covers only the payload bits; the trailer is compared, not folded in.
  assign crc_init = (state == IDLE);
  assign crc_en   = (state == SHIFT) && !cs_s && sample && (bit_cnt < CNT_PAY);
  assign crc_bad  = (CRC_EN != 0) && (crc != shreg[15:0]);

  spi_crc16_ser u_crc (
    .clk  (CLK),
    .rst  (RESET),
    .init (crc_init),
    .en   (crc_en),
    .din  (mosi_s),
    .crc  (crc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= WAIT_CS;
      bit_cnt     <= '0;
      shreg       <= '0;
      to_cnt      <= '0;
      FRAME_DATA  <= '0;
      FRAME_VALID <= 1'b0;
      ERR_LEN     <= 1'b0;
      ERR_CRC     <= 1'b0;
      ERR_OVF     <= 1'b0;
      ERR_TO      <= 1'b0;
      FRAME_CNT   <= '0;
      BUSY        <= 1'b0;
    end else begin
      ERR_LEN <= 1'b0;
      ERR_CRC <= 1'b0;
      ERR_OVF <= 1'b0;
      ERR_TO  <= 1'b0;
      if (FRAME_VALID && FRAME_READY) FRAME_VALID <= 1'b0;

      case (state)
        WAIT_CS: begin
          BUSY <= !cs_s;
          if (cs_s) state <= IDLE;
        end
        IDLE: begin
          bit_cnt <= '0;
          shreg   <= '0;
          to_cnt  <= '0;
          BUSY    <= !cs_s;
          if (!cs_s) state <= SHIFT;
        end
        SHIFT: begin
          BUSY <= 1'b1;
          if (cs_s) begin
            state <= CHECK;
          end else if (sample) begin
            shreg  <= {shreg[TOTAL_BITS-2:0], mosi_s};
            to_cnt <= '0;
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state  <= ABORT;
            ERR_TO <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          if (bit_cnt != CNT_TOTAL) begin
            ERR_LEN <= 1'b1;
          end else if (crc_bad) begin
            ERR_CRC <= 1'b1;
          end else if (FRAME_VALID && !FRAME_READY) begin
            ERR_OVF <= 1'b1;
          end else begin
            FRAME_DATA  <= shreg[TOTAL_BITS-1 -: FRAME_BITS];
            FRAME_VALID <= 1'b1;
            FRAME_CNT   <= FRAME_CNT + 1'b1;
          end
        end
        ABORT: begin
          BUSY <= !cs_s;
          if (cs_s) state <= IDLE;
        end
        default: begin
          state <= WAIT_CS;
          BUSY  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed + randomized bench for spi_frame_rx: a CRC-enabled 72-bit instance
// and a default 408-bit no-CRC instance share SCLK/MOSI with separate CS lines.
module tb_spi_frame_rx;
  import spi_frame_pkg::*;

  logic clk = 1'b0;
  logic reset, sclk, mosi, cs_a, cs_b, rdy_a, rdy_b;
  logic [71:0]  fd_a;
  logic [407:0] fd_b;
  logic fv_a, fv_b, el_a, el_b, ec_a, ec_b, eo_a, eo_b, et_a, et_b, busy_a, busy_b;
  logic [15:0] fc_a, fc_b;

  int n_asrt = 0;
  int n_fail = 0;
  int e_len[2], e_crc[2], e_ovf[2], e_to[2];
  int s_len[2], s_crc[2], s_ovf[2], s_to[2];

  always #5 clk = ~clk;

  spi_frame_rx #(.FRAME_BITS(72), .CRC_EN(1), .TIMEOUT_CYC(200)) dut_a (
    .CLK(clk), .RESET(reset), .SCLK(sclk), .CS(cs_a), .MOSI(mosi),
    .FRAME_DATA(fd_a), .FRAME_VALID(fv_a), .FRAME_READY(rdy_a),
    .ERR_LEN(el_a), .ERR_CRC(ec_a), .ERR_OVF(eo_a), .ERR_TO(et_a),
    .FRAME_CNT(fc_a), .BUSY(busy_a)
  );

  spi_frame_rx #(.FRAME_BITS(408), .CRC_EN(0)) dut_b (
    .CLK(clk), .RESET(reset), .SCLK(sclk), .CS(cs_b), .MOSI(mosi),
    .FRAME_DATA(fd_b), .FRAME_VALID(fv_b), .FRAME_READY(rdy_b),
    .ERR_LEN(el_b), .ERR_CRC(ec_b), .ERR_OVF(eo_b), .ERR_TO(et_b),
    .FRAME_CNT(fc_b), .BUSY(busy_b)
  );

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_len[i] = 0; e_crc[i] = 0; e_ovf[i] = 0; e_to[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (el_a) e_len[0] = e_len[0] + 1;
    if (ec_a) e_crc[0] = e_crc[0] + 1;
    if (eo_a) e_ovf[0] = e_ovf[0] + 1;
    if (et_a) e_to[0]  = e_to[0] + 1;
    if (el_b) e_len[1] = e_len[1] + 1;
    if (ec_b) e_crc[1] = e_crc[1] + 1;
    if (eo_b) e_ovf[1] = e_ovf[1] + 1;
    if (et_b) e_to[1]  = e_to[1] + 1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int s);
    s_len[s] = e_len[s]; s_crc[s] = e_crc[s]; s_ovf[s] = e_ovf[s]; s_to[s] = e_to[s];
  endtask

  task automatic chk_err(input int s, input string tag, input int l, input int c, input int o, input int t);
    chk({tag, "_len"}, 512'(e_len[s] - s_len[s]), 512'(l));
    chk({tag, "_crc"}, 512'(e_crc[s] - s_crc[s]), 512'(c));
    chk({tag, "_ovf"}, 512'(e_ovf[s] - s_ovf[s]), 512'(o));
    chk({tag, "_to"},  512'(e_to[s] - s_to[s]),   512'(t));
  endtask

  // Shift n bits MSB first (bits[n-1] first); optionally raise CS on a falling CLK edge.
  task automatic send_frame(input int s, input logic [511:0] bits, input int n, input bit raise);
    if (s == 1) cs_b = 1'b0; else cs_a = 1'b0;
    #47;
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0; mosi = bits[i]; #25;
      sclk = 1'b1; #25;
    end
    sclk = 1'b0; #30;
    if (raise) begin
      @(negedge clk);
      if (s == 1) cs_b = 1'b1; else cs_a = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic consume(input int s);
    @(negedge clk);
    if (s == 1) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0; rdy_b = 1'b0;
    chk(s == 1 ? "drop_b" : "drop_a", 512'(s == 1 ? fv_b : fv_a), 512'(0));
  endtask

  function automatic logic [15:0] ref_crc(input logic [71:0] p);
    logic [15:0] c;
    c = CRC16_INIT;
    for (int i = 71; i >= 0; i--) c = crc16_next(c, p[i]);
    return c;
  endfunction

  function automatic logic [71:0] rand72();
    logic [71:0] p;
    p[31:0]  = $urandom;
    p[63:32] = $urandom;
    p[71:64] = 8'($urandom);
    return p;
  endfunction

  initial begin
    logic [71:0]  p, p1;
    logic [15:0]  t;
    logic [407:0] vec, rb;
    logic [511:0] junk;
    int exp_cnt_a, kind, n;

    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    exp_cnt_a = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid_a", 512'(fv_a), 512'(0));
    chk("rst_cnt_a",   512'(fc_a), 512'(0));
    chk("rst_busy_a",  512'(busy_a), 512'(0));
    chk("rst_data_b",  512'(fd_b), 512'(0));
    chk("rst_errs_b",  512'({el_b, ec_b, eo_b, et_b}), 512'(0));
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy_a", 512'(busy_a), 512'(0));

    // Known CRC-16-CCITT check value for "123456789", with CS-rise to valid latency.
    snap(0);
    send_frame(0, 512'({72'h313233343536373839, 16'h29B1}), 88, 1'b1);
    repeat (3) @(negedge clk);
    chk("lat_early", 512'(fv_a), 512'(0));
    @(negedge clk);
    chk("lat_valid", 512'(fv_a), 512'(1));
    chk("ascii_data", 512'(fd_a), 512'(72'h313233343536373839));
    exp_cnt_a = 1;
    chk("ascii_cnt", 512'(fc_a), 512'(exp_cnt_a));
    settle();
    chk_err(0, "ascii", 0, 0, 0, 0);
    consume(0);

    snap(0);
    send_frame(0, 512'({72'h313233343536373839, 16'h29B0}), 88, 1'b1);
    settle();
    chk_err(0, "badcrc", 0, 1, 0, 0);
    chk("badcrc_valid", 512'(fv_a), 512'(0));
    chk("badcrc_cnt", 512'(fc_a), 512'(exp_cnt_a));

    // Random frames: good, corrupted trailer, or wrong length.
    for (int it = 0; it < 8; it++) begin
      p = rand72();
      kind = int'($urandom_range(2));
      snap(0);
      if (kind == 0) begin
        send_frame(0, 512'({p, ref_crc(p)}), 88, 1'b1);
        settle();
        exp_cnt_a++;
        chk_err(0, "rnd_good", 0, 0, 0, 0);
        chk("rnd_good_valid", 512'(fv_a), 512'(1));
        chk("rnd_good_data", 512'(fd_a), 512'(p));
        chk("rnd_good_cnt", 512'(fc_a), 512'(exp_cnt_a));
        consume(0);
      end else if (kind == 1) begin
        t = ref_crc(p) ^ (16'(1) << $urandom_range(15));
        send_frame(0, 512'({p, t}), 88, 1'b1);
        settle();
        chk_err(0, "rnd_crc", 0, 1, 0, 0);
        chk("rnd_crc_valid", 512'(fv_a), 512'(0));
      end else begin
        n = ($urandom_range(1) == 1) ? 88 + int'($urandom_range(1, 3)) : 88 - int'($urandom_range(1, 5));
        junk = {$urandom, $urandom, $urandom};
        send_frame(0, junk, n, 1'b1);
        settle();
        chk_err(0, "rnd_len", 1, 0, 0, 0);
        chk("rnd_len_cnt", 512'(fc_a), 512'(exp_cnt_a));
      end
    end

    // Holding register full: second good frame is dropped with ERR_OVF.
    p1 = rand72();
    p = rand72();
    snap(0);
    send_frame(0, 512'({p1, ref_crc(p1)}), 88, 1'b1);
    settle();
    send_frame(0, 512'({p, ref_crc(p)}), 88, 1'b1);
    settle();
    exp_cnt_a++;
    chk_err(0, "ovf", 0, 0, 1, 0);
    chk("ovf_cnt", 512'(fc_a), 512'(exp_cnt_a));
    chk("ovf_data", 512'(fd_a), 512'(p1));
    chk("ovf_valid", 512'(fv_a), 512'(1));
    consume(0);

    // Timeout: 10 edges then SCLK stops.
    snap(0);
    send_frame(0, 512'($urandom), 10, 1'b0);
    repeat (210) @(negedge clk);
    chk("to_busy", 512'(busy_a), 512'(1));
    cs_a = 1'b1;
    settle();
    chk("to_busy_after", 512'(busy_a), 512'(0));
    chk_err(0, "timeout", 0, 0, 0, 1);
    p = rand72();
    send_frame(0, 512'({p, ref_crc(p)}), 88, 1'b1);
    settle();
    exp_cnt_a++;
    chk("to_next_data", 512'(fd_a), 512'(p));
    chk("to_next_cnt", 512'(fc_a), 512'(exp_cnt_a));
    consume(0);

    // CS glitch with no sample edges.
    snap(0);
    @(negedge clk); cs_a = 1'b0;
    repeat (3) @(negedge clk); cs_a = 1'b1;
    settle();
    chk_err(0, "glitch", 1, 0, 0, 0);

    // 408-bit default instance, no CRC.
    vec = {64'h1, 48'h280000000000, 48'h2cbd3f, 32'h1, 64'd50000, 16'd10, 8'h0,
           32'd100, 32'd100, 32'd10, 32'd5};
    snap(1);
    send_frame(1, 512'(vec), 408, 1'b1);
    settle();
    chk("b_exact_data", 512'(fd_b), 512'(vec));
    chk("b_exact_cnt", 512'(fc_b), 512'(1));
    chk_err(1, "b_exact", 0, 0, 0, 0);
    consume(1);
    snap(1);
    send_frame(1, 512'(vec), 407, 1'b1);
    settle();
    chk_err(1, "b_407", 1, 0, 0, 0);
    snap(1);
    send_frame(1, 512'({vec, 1'b1}), 409, 1'b1);
    settle();
    chk_err(1, "b_409", 1, 0, 0, 0);
    chk("b_len_cnt", 512'(fc_b), 512'(1));
    for (int i = 0; i < 13; i++) rb[i*32 +: 32] = $urandom;
    send_frame(1, 512'(rb), 408, 1'b1);
    settle();
    chk("b_rand_data", 512'(fd_b), 512'(rb));
    chk("b_rand_cnt", 512'(fc_b), 512'(2));

    // CS held low across reset release: nothing until CS rises.
    @(negedge clk); reset = 1'b1; cs_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_cnt_a = 0;
    snap(0);
    repeat (30) @(negedge clk);
    chk("csl_valid", 512'(fv_a), 512'(0));
    cs_a = 1'b1;
    settle();
    chk_err(0, "cs_low_reset", 0, 0, 0, 0);
    p = rand72();
    send_frame(0, 512'({p, ref_crc(p)}), 88, 1'b1);
    settle();
    exp_cnt_a++;
    chk("csl_data", 512'(fd_a), 512'(p));
    chk("csl_cnt", 512'(fc_a), 512'(exp_cnt_a));

    // Reset mid-SHIFT while a frame is still held: async clear, no pulses.
    snap(0);
    send_frame(0, 512'($urandom), 20, 1'b0);
    @(negedge clk);
    chk("mid_busy_pre", 512'({busy_a, fv_a}), 512'(2'b11));
    #3 reset = 1'b1;
    #1;
    chk("mid_busy_rst", 512'(busy_a), 512'(0));
    chk("mid_valid_rst", 512'(fv_a), 512'(0));
    cs_a = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk_err(0, "mid_reset", 0, 0, 0, 0);
    chk("mid_cnt", 512'(fc_a), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
